dual_dist_ram_clr: RTL

//  Parametrised successor to the dual-port async distributed RAM: one write port with

---
 rtl/dual_dist_ram_clr_if.sv | 45 ++++
 rtl/dual_dist_ram_clr.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dual_dist_ram_clr_if.sv
// rtl/dual_dist_ram_clr_if.sv - bus bundle for the clearable dual-port distributed RAM
// Purpose: groups the clear-control, write-port and read-port signals of
//          dual_dist_ram_clr so requester and RAM connect through one port.
// Signals:
//   clr_req          requester -> RAM   start a zero-fill sweep (honoured in IDLE only)
//   clr_busy         RAM -> requester   sweep in progress
//   clr_done         RAM -> requester   one-cycle pulse after the last row is cleared
//   wr_ram_rdy       RAM -> requester   writes accepted (low while sweeping)
//   wr_ram_enb/be/addr/data             write strobe, lane enables, address, data
//   rd_ram_enb/addr                     read strobe and address
//   output_ram_data  RAM -> requester   read data
//   rd_ram_vld       RAM -> requester   output_ram_data valid
// Modports: master = requester side, slave = RAM side.
interface dual_dist_ram_clr_if #(
   parameter int RAM_WIDTH     = 72,
   parameter int RAM_ADDR_BITS = 8,
   parameter int BYTE_WIDTH    = 8
);
   localparam int NB = RAM_WIDTH / BYTE_WIDTH;

   logic                     clr_req;
   logic                     clr_busy;
   logic                     clr_done;
   logic                     wr_ram_rdy;
   logic                     wr_ram_enb;
   logic [NB-1:0]            wr_ram_be;
   logic [RAM_ADDR_BITS-1:0] wr_ram_addr;
   logic [RAM_WIDTH-1:0]     wr_ram_data;
   logic                     rd_ram_enb;
   logic [RAM_ADDR_BITS-1:0] rd_ram_addr;
   logic [RAM_WIDTH-1:0]     output_ram_data;
   logic                     rd_ram_vld;

   modport master (
      output clr_req, wr_ram_enb, wr_ram_be, wr_ram_addr, wr_ram_data,
             rd_ram_enb, rd_ram_addr,
      input  clr_busy, clr_done, wr_ram_rdy, output_ram_data, rd_ram_vld
   );

   modport slave (
      input  clr_req, wr_ram_enb, wr_ram_be, wr_ram_addr, wr_ram_data,
             rd_ram_enb, rd_ram_addr,
      output clr_busy, clr_done, wr_ram_rdy, output_ram_data, rd_ram_vld
   );
endinterface

// File: rtl/dual_dist_ram_clr.sv
// rtl/dual_dist_ram_clr.sv - dual-port distributed RAM with byte lanes and hardware clear
// Purpose: one write port with per-lane enables, one read port with 0/1-cycle
//          latency (RD_LATENCY) and a sweep sequencer that zero-fills every row
//          after reset or on clr_req, so stale buffer contents never leak out.
// Ports:
//   clk      single clock, all state on posedge
//   reset    asynchronous, active-high; restarts the clear sweep at row 0
//   ram_if   dual_dist_ram_clr_if.slave (clear control, write port, read port)
// Configuration macro: RAM_BYPASS_EN - when defined, a read hitting the row being
//   written in the same cycle returns the merged new row instead of the old one.
module dual_dist_ram_clr #(
   parameter int RAM_WIDTH     = 72,
   parameter int RAM_ADDR_BITS = 8,
   parameter int BYTE_WIDTH    = 8,
   parameter int RD_LATENCY    = 1
) (
   input logic                clk,
   input logic                reset,
   dual_dist_ram_clr_if.slave ram_if
);
   localparam int NB    = RAM_WIDTH / BYTE_WIDTH;
   localparam int DEPTH = 2 ** RAM_ADDR_BITS;
   localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = {RAM_ADDR_BITS{1'b1}};

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_DONE  = 2'd1,
      ST_IDLE  = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [RAM_ADDR_BITS-1:0] sweep_q, sweep_d;

   logic [RAM_WIDTH-1:0]     mem [DEPTH];

   logic                     busy;
   logic                     wr_fire;
   logic                     rd_ok;
   logic [RAM_WIDTH-1:0]     wr_row_old;
   logic [RAM_WIDTH-1:0]     wr_row_new;
   logic                     mem_we;
   logic [RAM_ADDR_BITS-1:0] mem_waddr;
   logic [RAM_WIDTH-1:0]     mem_wdata;
   logic [RAM_WIDTH-1:0]     rd_row;

   // Clear sequencer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      unique case (state_q)
         ST_CLEAR: begin
            // counter wraps to 0 on the last row, ready for the next request
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == LAST_ADDR) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         ST_IDLE: begin
            if (ram_if.clr_req) begin
               state_d = ST_CLEAR;
               sweep_d = '0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   assign busy              = (state_q == ST_CLEAR);
   assign ram_if.clr_busy   = busy;
   assign ram_if.clr_done   = (state_q == ST_DONE);
   assign ram_if.wr_ram_rdy = ~busy;

   // Write port: merge enabled lanes into the current row contents
   assign wr_fire = ram_if.wr_ram_enb & ~busy & (|ram_if.wr_ram_be);

   always_comb begin
      wr_row_old = mem[ram_if.wr_ram_addr];
      wr_row_new = wr_row_old;
      for (int i = 0; i < NB; i++) begin
         if (ram_if.wr_ram_be[i]) begin
            wr_row_new[i*BYTE_WIDTH +: BYTE_WIDTH] = ram_if.wr_ram_data[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   // Single physical write port shared between the sweep and user writes;
   // the sweep always wins, which is what drops writes issued while busy.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = ram_if.wr_ram_addr;
      mem_wdata = wr_row_new;
      if (busy) begin
         mem_we    = 1'b1;
         mem_waddr = sweep_q;
         mem_wdata = '0;
      end else if (wr_fire) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Read port
   assign rd_ok = ram_if.rd_ram_enb & ~busy;

`ifdef RAM_BYPASS_EN
   assign rd_row = (wr_fire && (ram_if.rd_ram_addr == ram_if.wr_ram_addr))
                   ? wr_row_new : mem[ram_if.rd_ram_addr];
`else
   assign rd_row = mem[ram_if.rd_ram_addr];
`endif

   generate
      if (RD_LATENCY == 0) begin : g_async_rd
         assign ram_if.output_ram_data = rd_row;
         assign ram_if.rd_ram_vld      = rd_ok;
      end else begin : g_reg_rd
         logic [RAM_WIDTH-1:0] rd_data_q, rd_data_d;
         logic                 rd_vld_q;

         // data holds when no valid read is issued
         assign rd_data_d = rd_ok ? rd_row : rd_data_q;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               rd_data_q <= '0;
               rd_vld_q  <= 1'b0;
            end else begin
               rd_data_q <= rd_data_d;
               rd_vld_q  <= rd_ok;
            end
         end

         assign ram_if.output_ram_data = rd_data_q;
         assign ram_if.rd_ram_vld      = rd_vld_q;
      end
   endgenerate
endmodule
